// File: rtl/bus_sram_bridge.sv
// Word-bus slave that turns single/burst (1-15 beat) read and write requests
// into accesses on a synchronous single-port 32-bit SRAM, one transaction at a time.
package bus_sram_pkg;

    typedef struct packed {
        logic        awvalid;
        logic [31:0] waddr;
        logic [3:0]  wlen;
        logic        wlast;
        logic        wvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        bready;
        logic        arvalid;
        logic [31:0] araddr;
        logic [3:0]  rlen;
        logic        rready;
    } bus_query_req_t;

    // rready here is the read-address accept back to the master.
    typedef struct packed {
        logic        awready;
        logic        wready;
        logic        bvalid;
        logic        rready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        rlast;
    } bus_query_resp_t;

endpackage

module bus_sram_bridge
    import bus_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  bus_query_req_t        bus_req,
    output bus_query_resp_t       bus_resp,
    output logic                  sram_en,
    output logic [3:0]            sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WR_DATA    = 3'd1,
        WR_RESP    = 3'd2,
        RD_ISSUE   = 3'd3,
        RD_CAPTURE = 3'd4,
        RD_DATA    = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            len_q, len_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  rlast_q, rlast_d;
    logic                  bvalid_q, rvalid_q;

    logic                  aw_acc_s;
    logic                  ar_acc_s;
    logic                  wr_beat_s;
    logic                  sram_en_s;
    logic [3:0]            sram_we_s;
    logic                  unused_s;

    // Byte-address bits outside the word window and wlast carry no meaning here.
    assign unused_s = ^{bus_req.wlast,
                        bus_req.waddr[31:ADDR_WIDTH+2], bus_req.waddr[1:0],
                        bus_req.araddr[31:ADDR_WIDTH+2], bus_req.araddr[1:0]};

    // Next-state, handshake and SRAM strobe decode.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        rlast_d   = rlast_q;
        aw_acc_s  = 1'b0;
        ar_acc_s  = 1'b0;
        wr_beat_s = 1'b0;
        sram_en_s = 1'b0;
        sram_we_s = 4'h0;
        case (state_q)
            IDLE: begin
                if (bus_req.awvalid && (bus_req.wlen != 4'd0)) begin
                    aw_acc_s = 1'b1;
                    addr_d   = bus_req.waddr[ADDR_WIDTH+1:2];
                    len_d    = bus_req.wlen;
                    cnt_d    = 4'd0;
                    state_d  = WR_DATA;
                end else if (bus_req.arvalid && (bus_req.rlen != 4'd0)) begin
                    ar_acc_s = 1'b1;
                    addr_d   = bus_req.araddr[ADDR_WIDTH+1:2];
                    len_d    = bus_req.rlen;
                    cnt_d    = 4'd0;
                    state_d  = RD_ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_DATA: begin
                if (bus_req.wvalid) begin
                    wr_beat_s = 1'b1;
                    sram_en_s = 1'b1;
                    sram_we_s = bus_req.wstrb;
                    addr_d    = addr_q + ADDR_WIDTH'(1);
                    cnt_d     = cnt_q + 4'd1;
                    // Burst length comes from wlen alone; wlast is ignored.
                    if (cnt_q == (len_q - 4'd1)) begin
                        state_d = WR_RESP;
                    end else begin
                        state_d = WR_DATA;
                    end
                end else begin
                    state_d = WR_DATA;
                end
            end
            WR_RESP: begin
                if (bus_req.bready) begin
                    state_d = IDLE;
                end else begin
                    state_d = WR_RESP;
                end
            end
            RD_ISSUE: begin
                sram_en_s = 1'b1;
                state_d   = RD_CAPTURE;
            end
            RD_CAPTURE: begin
                rdata_d = sram_rdata;
                rlast_d = (cnt_q == (len_q - 4'd1));
                state_d = RD_DATA;
            end
            RD_DATA: begin
                if (bus_req.rready) begin
                    if (rlast_q) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        cnt_d   = cnt_q + 4'd1;
                        state_d = RD_ISSUE;
                    end
                end else begin
                    state_d = RD_DATA;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, burst context and registered response flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            len_q    <= 4'd0;
            cnt_q    <= 4'd0;
            rdata_q  <= 32'h0;
            rlast_q  <= 1'b0;
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rlast_q  <= rlast_d;
            bvalid_q <= (state_d == WR_RESP);
            rvalid_q <= (state_d == RD_DATA);
        end
    end

    assign bus_resp.awready = aw_acc_s;
    assign bus_resp.wready  = wr_beat_s;
    assign bus_resp.bvalid  = bvalid_q;
    assign bus_resp.rready  = ar_acc_s;
    assign bus_resp.rvalid  = rvalid_q;
    assign bus_resp.rdata   = rdata_q;
    assign bus_resp.rlast   = rlast_q;

    // Address and data are forced to zero whenever the SRAM is not enabled.
    assign sram_en    = sram_en_s;
    assign sram_we    = sram_we_s;
    assign sram_addr  = sram_en_s ? addr_q : '0;
    assign sram_wdata = wr_beat_s ? bus_req.wdata : 32'h0;

endmodule

// File: tb/tb_bus_sram_bridge.sv
// Directed bench for bus_sram_bridge: vector table of single-word write/readback
// cases plus hand-written burst, wrap, arbitration, zero-length and reset sequences.
module tb_bus_sram_bridge;
    import bus_sram_pkg::*;

    localparam int AW = 8;

    logic            clk;
    logic            rst_n;
    bus_query_req_t  req;
    bus_query_resp_t resp;
    logic            sram_en;
    logic [3:0]      sram_we;
    logic [AW-1:0]   sram_addr;
    logic [31:0]     sram_wdata;
    logic [31:0]     sram_rdata;

    logic [31:0]     mem   [0:255];
    logic [31:0]     model [0:255];

    int n_vec;
    int n_err;

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] pre;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [6];

    bus_sram_bridge #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus_req    (req),
        .bus_resp   (resp),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port SRAM with byte enables and registered read data.
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we == 4'h0) begin
                sram_rdata <= mem[sram_addr];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input logic [7:0] wi, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) model[wi][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic write_burst(input logic [31:0] addr, input logic [3:0] len,
                               input logic [31:0] d0, input logic [3:0] strb);
        logic [7:0] wi;
        req.awvalid = 1'b1;
        req.waddr   = addr;
        req.wlen    = len;
        req.wvalid  = 1'b1;
        req.wdata   = d0;
        req.wstrb   = strb;
        #1;
        check("awready", 32'(resp.awready), 32'd1);
        check("ar_blocked_by_write", 32'(resp.rready), 32'd0);
        check("wvalid_at_accept_ignored", 32'({resp.wready, sram_en}), 32'd0);
        tick();
        req.awvalid = 1'b0;
        for (int i = 0; i < int'(len); i++) begin
            wi         = addr[9:2] + 8'(i);
            req.wvalid = 1'b1;
            req.wdata  = d0 + 32'(i);
            req.wstrb  = strb;
            req.wlast  = (i == int'(len) - 1);
            #1;
            check("wready", 32'(resp.wready), 32'd1);
            check("wr_en_we", 32'({sram_en, sram_we}), 32'({1'b1, strb}));
            check("wr_addr", 32'(sram_addr), 32'(wi));
            check("wr_data", sram_wdata, d0 + 32'(i));
            check("bvalid_early", 32'(resp.bvalid), 32'd0);
            model_write(wi, d0 + 32'(i), strb);
            tick();
        end
        req.wvalid = 1'b0;
        req.wlast  = 1'b0;
        check("bvalid", 32'(resp.bvalid), 32'd1);
        req.bready = 1'b1;
        tick();
        req.bready = 1'b0;
        check("bvalid_drop", 32'(resp.bvalid), 32'd0);
    endtask

    task automatic read_burst(input logic [31:0] addr, input logic [3:0] len,
                              input bit stall, output logic [31:0] last);
        logic [7:0] wi;
        last        = 32'h0;
        req.arvalid = 1'b1;
        req.araddr  = addr;
        req.rlen    = len;
        #1;
        check("arready", 32'(resp.rready), 32'd1);
        tick();
        req.arvalid = 1'b0;
        for (int i = 0; i < int'(len); i++) begin
            wi = addr[9:2] + 8'(i);
            check("rd_issue_en_we", 32'({sram_en, sram_we}), 32'h10);
            check("rd_issue_addr", 32'(sram_addr), 32'(wi));
            check("rvalid_early", 32'(resp.rvalid), 32'd0);
            tick();
            check("rd_capture_idle", 32'({sram_en, resp.rvalid}), 32'd0);
            tick();
            check("rvalid", 32'(resp.rvalid), 32'd1);
            check("rdata", resp.rdata, model[wi]);
            check("rlast", 32'(resp.rlast), 32'(i == int'(len) - 1));
            if (stall) begin
                req.rready = 1'b0;
                tick();
                check("rvalid_held", 32'(resp.rvalid), 32'd1);
                check("rdata_held", resp.rdata, model[wi]);
                check("rlast_held", 32'(resp.rlast), 32'(i == int'(len) - 1));
            end
            last       = resp.rdata;
            req.rready = 1'b1;
            tick();
            req.rready = 1'b0;
        end
        check("rvalid_drop", 32'(resp.rvalid), 32'd0);
    endtask

    initial begin
        logic [31:0] got;
        logic        zl_bad;
        n_vec = 0;
        n_err = 0;

        vecs[0] = '{32'h0000_0100, 32'h0000_0000, 32'hDEAD_BEEF, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF};
        vecs[1] = '{32'h0000_0104, 32'hFFFF_FFFF, 32'h0000_0000, 4'h5, 32'h0000_0104, 32'hFF00_FF00};
        vecs[2] = '{32'h0000_0108, 32'h1234_5678, 32'hAABB_CCDD, 4'h0, 32'h0000_0108, 32'h1234_5678};
        vecs[3] = '{32'h0000_010C, 32'h1111_1111, 32'h2222_2222, 4'h8, 32'h0000_010C, 32'h2211_1111};
        vecs[4] = '{32'h0000_03FF, 32'h0000_0000, 32'hCAFE_F00D, 4'h3, 32'h0000_03FC, 32'h0000_F00D};
        vecs[5] = '{32'hFFFF_F410, 32'h0000_0000, 32'h5A5A_5A5A, 4'hF, 32'h0000_0012, 32'h5A5A_5A5A};

        req        = '0;
        rst_n      = 1'b0;
        tick();
        tick();
        check("rst_ctrl", 32'({resp.awready, resp.wready, resp.bvalid, resp.rready, resp.rvalid, resp.rlast}), 32'd0);
        check("rst_rdata", resp.rdata, 32'd0);
        check("rst_sram", 32'({sram_en, sram_we, sram_addr}), 32'd0);
        check("rst_wdata", sram_wdata, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            write_burst(vecs[v].waddr, 4'd1, vecs[v].pre, 4'hF);
            write_burst(vecs[v].waddr, 4'd1, vecs[v].data, vecs[v].strb);
            read_burst(vecs[v].raddr, 4'd1, 1'b0, got);
            check("tbl_readback", got, vecs[v].exp);
        end

        // Burst with read backpressure
        write_burst(32'h0000_0200, 4'd4, 32'h0000_0001, 4'hF);
        read_burst(32'h0000_0200, 4'd4, 1'b1, got);
        check("burst_last_data", got, 32'h0000_0004);

        // Burst wrapping past the last word
        write_burst(32'h0000_03FC, 4'd2, 32'h7777_0000, 4'hF);
        read_burst(32'h0000_0000, 4'd1, 1'b0, got);
        check("wrap_word0", got, 32'h7777_0001);
        read_burst(32'h0000_03FC, 4'd2, 1'b0, got);

        // Simultaneous write and read: write first
        req.arvalid = 1'b1;
        req.araddr  = 32'h0000_0300;
        req.rlen    = 4'd1;
        write_burst(32'h0000_0300, 4'd1, 32'hBEEF_0001, 4'hF);
        read_burst(32'h0000_0300, 4'd1, 1'b0, got);
        check("arb_read_after_write", got, 32'hBEEF_0001);

        // Zero-length requests are never accepted
        zl_bad      = 1'b0;
        req.arvalid = 1'b1;
        req.araddr  = 32'h0000_0100;
        req.rlen    = 4'd0;
        req.awvalid = 1'b1;
        req.waddr   = 32'h0000_0100;
        req.wlen    = 4'd0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (resp.rready || resp.awready || sram_en) zl_bad = 1'b1;
            tick();
        end
        check("zero_len_ignored", 32'(zl_bad), 32'd0);
        req = '0;
        read_burst(32'h0000_0100, 4'd1, 1'b0, got);
        check("zero_len_then_read", got, 32'hDEAD_BEEF);

        // Reset in the middle of a 4-beat write
        write_burst(32'h0000_0240, 4'd4, 32'hA5A5_0000, 4'hF);
        req.awvalid = 1'b1;
        req.waddr   = 32'h0000_0240;
        req.wlen    = 4'd4;
        tick();
        req.awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req.wvalid = 1'b1;
            req.wdata  = 32'hC0DE_0001 + 32'(i);
            req.wstrb  = 4'hF;
            model_write(8'h90 + 8'(i), 32'hC0DE_0001 + 32'(i), 4'hF);
            tick();
        end
        req.wdata = 32'hC0DE_0003;
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_ctrl", 32'({resp.awready, resp.wready, resp.bvalid, resp.rready, resp.rvalid, resp.rlast}), 32'd0);
        check("midrst_rdata", resp.rdata, 32'd0);
        check("midrst_sram", 32'({sram_en, sram_we, sram_addr}), 32'd0);
        check("midrst_wdata", sram_wdata, 32'd0);
        req = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("midrst_no_resp", 32'({resp.bvalid, resp.rvalid}), 32'd0);
        read_burst(32'h0000_0240, 4'd4, 1'b0, got);
        check("midrst_beat4_unchanged", got, 32'hA5A5_0003);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
